ek_byte_decode: RTL and testbench

Streaming ByteDecode_12 for the ML-KEM encapsulation key, the inverse of the keygen ByteEncode_12 path. Consumes ek (384·K + 32 bytes) as 64-bit words over a valid/ready stream. Unpacks the K polynomials of t̂, reduces each coefficient mod q and flags the FIPS 203 modulus-check failure. Presents t̂ and ρ as registered outputs with a one-cycle done_o pulse, matching the run_i/done_o convention of the other KEM modules. Sits on the encapsulation input path and feeds LOM (polyvec_t_i) and sampleA (rho_i).

---
 rtl/ek_byte_decode_pkg.sv | 9 +
 rtl/ek_byte_decode_if.sv | 8 +
 rtl/ek_byte_decode_dec12.sv | 16 +
 rtl/ek_byte_decode.sv | 74 +++++++
 tb/tb_ek_byte_decode.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ek_byte_decode_pkg.sv
// ek_byte_decode_pkg: shared KEM types and constants for the ek ByteDecode_12 path
package ek_byte_decode_pkg;
    localparam int ML_KEM_K = 3;
    localparam int KEM_Q = 3329;
    localparam int EK_T_WORDS = 48 * ML_KEM_K;
    localparam int EK_RHO_WORDS = 4;
    typedef logic [255:0][11:0] poly_t;
    typedef enum logic [1:0] {IDLE, LOAD_T, LOAD_RHO, DONE} ek_dec_state_t;
endpackage

// File: rtl/ek_byte_decode_if.sv
// ek_byte_decode_if: 64-bit valid/ready word stream carrying the encapsulation key
interface ek_byte_decode_if;
    logic [63:0] din;
    logic        din_vld;
    logic        din_rdy;
    modport master (output din, din_vld, input din_rdy);
    modport slave  (input din, din_vld, output din_rdy);
endinterface

// File: rtl/ek_byte_decode_dec12.sv
// poly_dec12_unit: splits a 192-bit group into 16 coefficients reduced mod q
module poly_dec12_unit
    import ek_byte_decode_pkg::*;
(
    input  logic [191:0]      blk,
    output logic [15:0][11:0] coef,
    output logic              over_q
);
    logic [15:0] over;
    // raw tops out at 4095 < 2q, so one conditional subtraction is a full reduction
    for (genvar j = 0; j < 16; j++) begin : g_c
        assign over[j] = blk[12*j +: 12] >= 12'(KEM_Q);
        assign coef[j] = over[j] ? blk[12*j +: 12] - 12'(KEM_Q) : blk[12*j +: 12];
    end
    assign over_q = |over;
endmodule

// File: rtl/ek_byte_decode.sv
// ek_byte_decode: streams ek words in, unpacks t-hat with modulus check and captures rho
module ek_byte_decode
    import ek_byte_decode_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  run_i,
    ek_byte_decode_if.slave       s,
    output poly_t [ML_KEM_K-1:0]  polyvec_t_o,
    output logic [255:0]          rho_o,
    output logic                  done_o,
    output logic                  err_o
);
    ek_dec_state_t     state, state_n;
    logic [1:0]        wsel, pidx, ridx;
    logic [3:0]        grp;
    logic [127:0]      hold;
    logic [15:0][11:0] coef;
    logic              over_q, acc, last_t;

    poly_dec12_unit u_dec (.blk({s.din, hold}), .coef(coef), .over_q(over_q));

    assign s.din_rdy = state == LOAD_T || state == LOAD_RHO;
    assign done_o    = state == DONE;
    assign acc       = s.din_vld & s.din_rdy;
    assign last_t    = wsel == 2'd2 && grp == 4'd15 && pidx == 2'(ML_KEM_K - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = run_i ? LOAD_T : IDLE;
            LOAD_T:   state_n = acc && last_t ? LOAD_RHO : LOAD_T;
            LOAD_RHO: state_n = acc && ridx == 2'(EK_RHO_WORDS - 1) ? DONE : LOAD_RHO;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            wsel        <= '0;
            grp         <= '0;
            pidx        <= '0;
            ridx        <= '0;
            hold        <= '0;
            polyvec_t_o <= '0;
            rho_o       <= '0;
            err_o       <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && run_i)
                err_o <= 1'b0;
            if (acc && state == LOAD_T) begin
                wsel <= wsel == 2'd2 ? 2'd0 : wsel + 2'd1;
                if (wsel == 2'd2) begin
                    grp <= grp + 4'd1;
                    if (grp == 4'd15)
                        pidx <= pidx == 2'(ML_KEM_K - 1) ? 2'd0 : pidx + 2'd1;
                    for (int j = 0; j < 16; j++)
                        polyvec_t_o[pidx][{grp, 4'(j)}] <= coef[j];
                    if (over_q)
                        err_o <= 1'b1;
                end else if (wsel == 2'd0)
                    hold[63:0] <= s.din;
                else
                    hold[127:64] <= s.din;
            end
            if (acc && state == LOAD_RHO) begin
                ridx <= ridx + 2'd1;
                rho_o[64*ridx +: 64] <= s.din;
            end
        end
    end
endmodule

// File: tb/tb_ek_byte_decode.sv
// tb_ek_byte_decode: vector table, random model-checked runs, backpressure and reset corners
module tb_ek_byte_decode;
    import ek_byte_decode_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i = 1'b0;
    logic                 run_i = 1'b0;
    poly_t [ML_KEM_K-1:0] polyvec_t_o;
    logic [255:0]         rho_o;
    logic                 done_o, err_o;

    ek_byte_decode_if bus ();

    ek_byte_decode dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .s(bus),
        .polyvec_t_o(polyvec_t_o), .rho_o(rho_o), .done_o(done_o), .err_o(err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    localparam int NW = EK_T_WORDS + EK_RHO_WORDS;

    logic [63:0]  ek [NW];
    int           exp_t [ML_KEM_K][256];
    logic [255:0] exp_rho;
    logic         exp_err;
    int           n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [63:0] w0;
        int          c0;
        int          c1;
        logic        err;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int byte_at(input int m);
        logic [63:0] w;
        w = ek[m / 8];
        return int'((w >> (8 * (m % 8))) & 64'hFF);
    endfunction

    // ByteDecode_12 straight from the byte-pair rule, then mod q by remainder
    task automatic model();
        exp_err = 1'b0;
        for (int n = 0; n < 256 * ML_KEM_K; n++) begin
            int m, raw;
            m = 3 * (n / 2);
            raw = (n % 2 == 0) ? byte_at(m) + 256 * (byte_at(m + 1) % 16)
                               : byte_at(m + 1) / 16 + 16 * byte_at(m + 2);
            exp_t[n / 256][n % 256] = raw % KEM_Q;
            if (raw >= KEM_Q) exp_err = 1'b1;
        end
        exp_rho = {ek[EK_T_WORDS+3], ek[EK_T_WORDS+2], ek[EK_T_WORDS+1], ek[EK_T_WORDS]};
    endtask

    task automatic verify(input string tag);
        int bp, bi;
        bp = -1;
        bi = 0;
        for (int p = 0; p < ML_KEM_K; p++)
            for (int i = 0; i < 256; i++)
                if (bp < 0 && int'(polyvec_t_o[p][i]) != exp_t[p][i]) begin
                    bp = p;
                    bi = i;
                end
        if (bp < 0) bp = 0;
        chk($sformatf("%s_t[%0d][%0d]", tag, bp, bi), 256'(polyvec_t_o[bp][bi]), 256'(exp_t[bp][bi]));
        chk({tag, "_rho"}, rho_o, exp_rho);
        chk({tag, "_err"}, 256'(err_o), 256'(exp_err));
    endtask

    // mode 0: din_vld always high; mode 1: din_vld toggles, low in the first cycle after run
    task automatic feed(input int mode, input bit busy, output int lat);
        int  idx, k;
        bit  a;
        idx = 0;
        k = 0;
        lat = -1;
        @(posedge clk_i); #1;
        run_i = 1'b1;
        bus.din_vld = 1'b1;
        bus.din = ek[0];
        @(posedge clk_i); #1;
        run_i = 1'b0;
        while (k < 1000) begin
            k++;
            bus.din_vld = mode == 0 ? 1'b1 : (k % 2 == 0);
            bus.din = idx < NW ? ek[idx] : {$urandom, $urandom};
            run_i = busy && (k == 10 || k == 11 || idx == NW);
            @(negedge clk_i);
            if (k == 1) chk("err_clear_on_run", 256'(err_o), 256'(0));
            if (done_o) begin
                lat = k;
                break;
            end
            a = bus.din_vld && bus.din_rdy;
            @(posedge clk_i); #1;
            if (a) idx++;
        end
        if (lat < 0) chk("done_timeout", 256'(k), 256'(0));
        chk("rdy_in_done", 256'(bus.din_rdy), 256'(0));
        chk("words_accepted", 256'(idx), 256'(NW));
        @(posedge clk_i); #1;
        run_i = 1'b0;
        bus.din_vld = 1'b0;
        @(negedge clk_i);
        chk("done_one_cycle", 256'(done_o), 256'(0));
        chk("idle_after_done", 256'(bus.din_rdy), 256'(0));
    endtask

    initial begin
        int           lat, lat_fr;
        poly_t [ML_KEM_K-1:0] sv_t;
        logic [255:0] sv_rho;
        logic         sv_err;
        logic [3:0]   r4;

        vt[0] = '{64'h2001,     1,    2,    1'b0};
        vt[1] = '{64'h0D00,     3328, 0,    1'b0};
        vt[2] = '{64'h0D01,     0,    0,    1'b1};
        vt[3] = '{64'hFFFFFF,   766,  766,  1'b1};
        vt[4] = '{64'h0,        0,    0,    1'b0};
        vt[5] = '{64'h00D01D00, 3328, 0,    1'b1};

        bus.din = '0;
        bus.din_vld = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("rst_rdy", 256'(bus.din_rdy), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));
        chk("rst_t_zero", 256'(|polyvec_t_o), 256'(0));
        chk("rst_rho", rho_o, 256'(0));

        foreach (ek[i]) ek[i] = '0;
        model();
        feed(0, 1'b0, lat);
        verify("zero_ek");
        chk("zero_latency", 256'(lat), 256'(NW + 1));

        for (int v = 0; v < 6; v++) begin
            foreach (ek[i]) ek[i] = '0;
            ek[0] = vt[v].w0;
            for (int r = 0; r < 4; r++) begin
                r4 = 4'(r + 1);
                ek[EK_T_WORDS + r] = {16{r4}};
            end
            model();
            feed(0, 1'b0, lat);
            verify($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_c0", v), 256'(polyvec_t_o[0][0]), 256'(vt[v].c0));
            chk($sformatf("vec%0d_c1", v), 256'(polyvec_t_o[0][1]), 256'(vt[v].c1));
            chk($sformatf("vec%0d_err", v), 256'(err_o), 256'(vt[v].err));
            chk($sformatf("vec%0d_rho", v), rho_o,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        end

        foreach (ek[i]) ek[i] = {$urandom, $urandom} & 64'h7777777777777777;
        model();
        feed(0, 1'b1, lat);
        verify("in_range_busy");

        foreach (ek[i]) ek[i] = {$urandom, $urandom};
        model();
        feed(0, 1'b0, lat_fr);
        verify("rnd_full");
        chk("rnd_full_latency", 256'(lat_fr), 256'(NW + 1));
        sv_t = polyvec_t_o;
        sv_rho = rho_o;
        sv_err = err_o;
        feed(1, 1'b1, lat);
        verify("rnd_bp");
        chk("bp_same_t", 256'(polyvec_t_o == sv_t), 256'(1));
        chk("bp_same_rho", rho_o, sv_rho);
        chk("bp_same_err", 256'(err_o), 256'(sv_err));
        chk("bp_extra_latency", 256'(lat - lat_fr), 256'(NW));

        foreach (ek[i]) ek[i] = {$urandom, $urandom};
        @(posedge clk_i); #1 run_i = 1'b1;
        @(posedge clk_i); #1 run_i = 1'b0;
        bus.din_vld = 1'b1;
        for (int i = 0; i < 70; i++) begin
            bus.din = ek[i];
            @(posedge clk_i); #1;
        end
        bus.din_vld = 1'b0;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_rdy", 256'(bus.din_rdy), 256'(0));
        chk("midrst_err", 256'(err_o), 256'(0));
        chk("midrst_t_zero", 256'(|polyvec_t_o), 256'(0));
        chk("midrst_rho", rho_o, 256'(0));
        model();
        feed(0, 1'b0, lat);
        verify("after_rst");
        chk("after_rst_latency", 256'(lat), 256'(NW + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
